// File: rtl/conc_op_loader_pkg.sv
// Shared types for the concatenation-operator front end: FSM encoding and the
// operand bundle layout consumed by the operator stage and its benches.
package conc_op_loader_pkg;

    localparam int unsigned A_W               = 4;
    localparam int unsigned B_W               = 4;
    localparam int unsigned C_W               = 8;
    localparam int unsigned NIBBLES_PER_FRAME = 5;

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_CH   = 3'd2,
        S_CL   = 3'd3,
        S_INV  = 3'd4,
        S_HOLD = 3'd5
    } state_e;

    typedef struct packed {
        logic [A_W-1:0] a;
        logic [B_W-1:0] b;
        logic [C_W-1:0] c;
        logic           inv;
    } operand_t;

    localparam operand_t OPERAND_RESET = '{a: 4'h0, b: 4'h0, c: 8'h00, inv: 1'b0};

endpackage

// File: rtl/conc_op_loader.sv
// Assembles 5-nibble frames into an operand bundle (a, b, c, inv) and holds it
// on a valid/ready interface until the operator stage takes it.
module conc_op_loader
    import conc_op_loader_pkg::*;
#(
    parameter int unsigned FRAME_CNT_W = 8,
    parameter int unsigned INV_CHECK   = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   in_valid,
    input  logic [3:0]             in_data,
    output logic                   in_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [3:0]             a,
    output logic [3:0]             b,
    output logic [7:0]             c,
    output logic                   inv,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic                   err
);

    localparam logic [FRAME_CNT_W-1:0] CNT_ONE = {{(FRAME_CNT_W-1){1'b0}}, 1'b1};

    state_e                 state_q,     state_d;
    operand_t               bundle_q,    bundle_d;
    logic                   out_valid_q, out_valid_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic                   err_q,       err_d;
    logic                   nib_acc_s;
    logic                   inv_bad_s;

    // in_ready must drop in the same cycle the FSM enters hold, so it is decoded from state
    assign in_ready  = (state_q != S_HOLD);
    assign nib_acc_s = in_valid & in_ready;
    assign inv_bad_s = (INV_CHECK != 32'd0) && (in_data[3:1] != 3'b000);

    // Next-state and datapath capture; clr wins over any nibble or downstream accept
    always_comb begin
        state_d     = state_q;
        bundle_d    = bundle_q;
        out_valid_d = out_valid_q;
        frame_cnt_d = frame_cnt_q;
        err_d       = err_q;
        if (clr) begin
            state_d     = S_A;
            out_valid_d = 1'b0;
        end else if (state_q == S_HOLD) begin
            if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
                frame_cnt_d = frame_cnt_q + CNT_ONE;
                state_d     = S_A;
            end else begin
                out_valid_d = out_valid_q;
            end
        end else if (nib_acc_s) begin
            case (state_q)
                S_A: begin
                    bundle_d.a = in_data;
                    state_d    = S_B;
                end
                S_B: begin
                    bundle_d.b = in_data;
                    state_d    = S_CH;
                end
                S_CH: begin
                    bundle_d.c[7:4] = in_data;
                    state_d         = S_CL;
                end
                S_CL: begin
                    bundle_d.c[3:0] = in_data;
                    state_d         = S_INV;
                end
                S_INV: begin
                    // A malformed inv nibble is flagged but the frame is still delivered
                    bundle_d.inv = in_data[0];
                    out_valid_d  = 1'b1;
                    state_d      = S_HOLD;
                    if (inv_bad_s) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                end
                default: begin
                    state_d = S_A;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_A;
            bundle_q    <= OPERAND_RESET;
            out_valid_q <= 1'b0;
            frame_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bundle_q    <= bundle_d;
            out_valid_q <= out_valid_d;
            frame_cnt_q <= frame_cnt_d;
            err_q       <= err_d;
        end
    end

    assign a         = bundle_q.a;
    assign b         = bundle_q.b;
    assign c         = bundle_q.c;
    assign inv       = bundle_q.inv;
    assign out_valid = out_valid_q;
    assign frame_cnt = frame_cnt_q;
    assign err       = err_q;

endmodule

// File: tb/tb_conc_op_loader.sv
// Scoreboard bench for conc_op_loader: stimulus pushes expected bundles, a
// negedge monitor pops and compares them on every downstream handshake.
module tb_conc_op_loader;
    import conc_op_loader_pkg::*;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] c;
        logic       inv;
        logic [7:0] cnt;
        logic       err;
    } exp_t;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       clr       = 1'b0;
    logic       in_valid  = 1'b0;
    logic [3:0] in_data   = 4'h0;
    logic       out_ready = 1'b0;

    logic       in_ready, out_valid, inv, err;
    logic [3:0] a, b;
    logic [7:0] c, frame_cnt;

    logic       in_ready0, out_valid0, inv0, err0;
    logic [3:0] a0, b0;
    logic [7:0] c0, frame_cnt0;

    int         checks = 0;
    int         errors = 0;
    exp_t       exp_q[$];
    logic [7:0] exp_cnt   = 8'd0;
    logic       err_model = 1'b0;

    conc_op_loader #(.FRAME_CNT_W(8), .INV_CHECK(1)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .a(a), .b(b), .c(c), .inv(inv), .frame_cnt(frame_cnt), .err(err)
    );

    conc_op_loader #(.FRAME_CNT_W(8), .INV_CHECK(0)) dut_nochk (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready0), .out_valid(out_valid0), .out_ready(out_ready),
        .a(a0), .b(b0), .c(c0), .inv(inv0), .frame_cnt(frame_cnt0), .err(err0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a handshake happens at the next posedge, so compare the presented bundle now
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !clr) begin
            exp_t e;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_bundle: got %0h with empty scoreboard", {a, b, c, inv});
            end else begin
                e = exp_q.pop_front();
                chk("bundle", {a, b, c, inv, frame_cnt, err},
                    {e.a, e.b, e.c, e.inv, e.cnt, e.err});
            end
        end
    end

    task automatic push_exp(input logic [19:0] f);
        exp_t e;
        e.a   = f[19:16];
        e.b   = f[15:12];
        e.c   = f[11:4];
        e.inv = f[0];
        if (f[3:1] != 3'b000) err_model = 1'b1;
        e.err   = err_model;
        e.cnt   = exp_cnt;
        exp_cnt = exp_cnt + 8'd1;
        exp_q.push_back(e);
    endtask

    task automatic send_nib(input logic [3:0] d, input bit gap);
        int t;
        t        = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        chk("in_ready_wait", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_frame(input logic [19:0] f, input bit gap, input bit delivered);
        if (delivered) push_exp(f);
        for (int i = 0; i < NIBBLES_PER_FRAME; i++) begin
            send_nib(f[19-4*i -: 4], gap);
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (out_valid && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        chk("out_valid_drop", {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {in_ready, out_valid, a, b, c, inv, frame_cnt, err}, 64'h200000000 >> 6);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset_in_ready", {63'd0, in_ready}, 64'd1);

        // Contiguous frame, downstream always ready
        out_ready = 1'b1;
        send_frame(20'hf0ff0, 1'b0, 1'b1);
        chk("out_valid_latency", {63'd0, out_valid}, 64'd1);
        wait_idle();
        chk("frame_cnt_1", {56'd0, frame_cnt}, 64'd1);

        // Backpressure: bundle held, in_ready low, stray nibbles ignored
        out_ready = 1'b0;
        send_frame(20'h00001, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
            chk("hold_bundle", {47'd0, a, b, c, inv}, 64'h1);
            in_valid = i[0];
            in_data  = 4'h7;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("hold_frame_cnt", {56'd0, frame_cnt}, 64'd1);
        out_ready = 1'b1;
        wait_idle();
        chk("frame_cnt_2", {56'd0, frame_cnt}, 64'd2);

        // Gapped nibble stream
        send_frame(20'hffff0, 1'b1, 1'b1);
        wait_idle();

        // clr discards a partial frame and the nibble offered alongside it
        send_nib(4'ha, 1'b0);
        send_nib(4'hb, 1'b0);
        send_nib(4'hc, 1'b0);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = 4'hd;
        @(posedge clk); #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        send_frame(20'h12340, 1'b0, 1'b1);
        wait_idle();

        // clr during hold with out_ready high: no count, data retained
        out_ready = 1'b0;
        send_frame(20'h5a5a0, 1'b0, 1'b0);
        chk("pre_clr_valid", {63'd0, out_valid}, 64'd1);
        out_ready = 1'b1;
        clr       = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        chk("clr_hold", {in_ready, out_valid, frame_cnt, a}, {50'd0, 1'b1, 1'b0, 8'd4, 4'h5});

        // Malformed inv nibble sets a sticky err only when checking is enabled
        send_frame(20'h00003, 1'b0, 1'b1);
        wait_idle();
        chk("err_set", {63'd0, err}, 64'd1);
        chk("err_nochk", {63'd0, err0}, 64'd0);
        send_frame(20'h11110, 1'b0, 1'b1);
        wait_idle();
        chk("err_sticky", {63'd0, err}, 64'd1);
        chk("err_nochk_2", {63'd0, err0}, 64'd0);

        // Reset asserted mid-hold clears everything immediately
        out_ready = 1'b0;
        send_frame(20'h76540, 1'b0, 1'b0);
        chk("pre_rst_valid", {63'd0, out_valid}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_hold", {in_ready, out_valid, frame_cnt, err, a}, {49'd0, 1'b1, 1'b0, 8'd0, 1'b0, 4'h0});
        @(posedge clk); #1;
        rst_n     = 1'b1;
        exp_cnt   = 8'd0;
        err_model = 1'b0;
        out_ready = 1'b1;

        // 256 frames wrap the counter back to zero
        for (int i = 0; i < 256; i++) begin
            v = i[7:0];
            send_frame({v[3:0], v[7:4], v, 4'h0}, 1'b0, 1'b1);
        end
        wait_idle();
        chk("frame_cnt_wrap", {56'd0, frame_cnt}, 64'd0);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drain", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
